rca_out_stage: RTL and testbench

Registered output stage directly downstream of the N-bit ripple-carry adder. It captures the adder's sum and carry-out together with the operand sign bits, derives status flags, and presents the result to the consumer over a valid/ready handshake. The 2-entry skid buffer keeps full throughput while cutting the combinational path from consumer back-pressure to the adder. It also keeps a wrapping count of delivered results.

---
 rtl/rca_out_stage.sv | 123 ++++++++++++
 tb/tb_rca_out_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca_out_stage.sv
// Registered output stage for the ripple-carry adder: captures sum/carry plus
// derived status flags into a 2-entry skid buffer and delivers them over valid/ready.
module rca_out_stage #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     s,
    input  logic             Cout,
    input  logic             x_msb,
    input  logic             y_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic [CNT_W-1:0] result_count
);

    localparam int EW = N + 4;

    // State bits are {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t          state_r;
    logic [EW-1:0]   main_r;
    logic [EW-1:0]   skid_r;
    logic [CNT_W-1:0] count_r;
    logic [EW-1:0]   in_entry_s;
    logic            in_hs_s;
    logic            out_hs_s;

    // Entry layout is {sum, cout, zero, neg, ovf}; flags come from the raw adder inputs.
    function automatic logic [EW-1:0] make_entry(
        input logic [N-1:0] sum,
        input logic         cout,
        input logic         xm,
        input logic         ym
    );
        logic zero;
        logic neg;
        logic ovf;
        zero = (sum == {N{1'b0}});
        neg  = sum[N-1];
        ovf  = (xm == ym) && (neg != xm);
        return {sum, cout, zero, neg, ovf};
    endfunction

    assign in_entry_s = make_entry(s, Cout, x_msb, y_msb);
    // in_ready depends only on registered state and rst, never on out_ready.
    assign in_ready   = !rst && !state_r[1];
    assign out_valid  = state_r[0];
    assign in_hs_s    = in_valid && in_ready;
    assign out_hs_s   = out_valid && out_ready;

    assign out_sum      = main_r[EW-1:4];
    assign out_cout     = main_r[3];
    assign out_zero     = main_r[2];
    assign out_neg      = main_r[1];
    assign out_ovf      = main_r[0];
    assign result_count = count_r;

    // Skid-buffer state machine, storage and delivered-result counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            main_r  <= {EW{1'b0}};
            skid_r  <= {EW{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_hs_s) begin
                        main_r  <= in_entry_s;
                        state_r <= ONE;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                ONE: begin
                    if (in_hs_s && out_hs_s) begin
                        main_r  <= in_entry_s;
                        state_r <= ONE;
                    end else if (out_hs_s) begin
                        state_r <= EMPTY;
                    end else if (in_hs_s) begin
                        skid_r  <= in_entry_s;
                        state_r <= TWO;
                    end else begin
                        state_r <= ONE;
                    end
                end
                TWO: begin
                    if (out_hs_s) begin
                        main_r  <= skid_r;
                        state_r <= ONE;
                    end else begin
                        state_r <= TWO;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase

            if (out_hs_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: tb/tb_rca_out_stage.sv
// Scoreboard bench for rca_out_stage: accepted inputs are queued with
// hand-computed flags, and a negedge monitor checks every delivered result.
module tb_rca_out_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] s = 8'h00;
    logic       Cout = 1'b0;
    logic       x_msb = 1'b0;
    logic       y_msb = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_cout;
    logic       out_zero;
    logic       out_neg;
    logic       out_ovf;
    logic [3:0] result_count;

    logic       ez = 1'b0;
    logic       en = 1'b0;
    logic       eo = 1'b0;

    int         n_checks = 0;
    int         n_fail   = 0;
    bit         mon_en   = 1'b0;
    logic [3:0] exp_cnt  = 4'd0;
    logic [11:0] q[$];

    rca_out_stage #(.N(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .Cout(Cout), .x_msb(x_msb), .y_msb(y_msb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_zero(out_zero),
        .out_neg(out_neg), .out_ovf(out_ovf),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [7:0] sv, input logic c,
                       input logic xm, input logic ym,
                       input logic z, input logic n, input logic o);
        in_valid = v; s = sv; Cout = c; x_msb = xm; y_msb = ym;
        ez = z; en = n; eo = o;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Push the expected entry once the DUT has captured an accepted input.
    always begin
        logic        r, hs;
        logic [11:0] e;
        @(negedge clk);
        r  = rst;
        hs = in_valid && in_ready;
        e  = {s, Cout, ez, en, eo};
        @(posedge clk);
        if (r) q.delete();
        else if (hs) q.push_back(e);
    end

    // Monitor: status checks every cycle, data check on each output handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst) && (q.size() < 2)});
            chk("result_count", {28'd0, result_count}, {28'd0, exp_cnt});
            if (rst) begin
                exp_cnt = 4'd0;
            end else if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got sum 0x%0h expected no result", out_sum);
                end else begin
                    chk("out_data", {20'd0, out_sum, out_cout, out_zero, out_neg, out_ovf},
                        {20'd0, q.pop_front()});
                end
                exp_cnt = exp_cnt + 4'd1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        // Reset with in_valid high
        out_ready = 1'b1;
        drv(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready2", {31'd0, in_ready}, 32'd0);
        chk("rst_out_bits", {20'd0, out_sum, out_cout, out_zero, out_neg, out_ovf}, 32'd0);
        chk("rst_count", {28'd0, result_count}, 32'd0);
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Flag vectors
        drv(1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); tick();
        drv(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        drv(1'b1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        idle(3);

        // Streaming: 10 back-to-back results
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(3);
        @(negedge clk);
        chk("stream_count", {28'd0, result_count}, 32'd10);
        tick();

        // Back-pressure: A, B, C with out_ready dropping after A
        do_reset();
        out_ready = 1'b1;
        drv(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        out_ready = 1'b0;
        drv(1'b1, 8'hB2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        drv(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        tick();
        @(negedge clk);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_sum", {24'd0, out_sum}, 32'hA1);
        tick();
        out_ready = 1'b1;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            tick();
        end
        chk("bp_c_accepted", {31'd0, acc}, 32'd1);
        idle(4);
        @(negedge clk);
        chk("bp_count", {28'd0, result_count}, 32'd3);
        tick();

        // Simultaneous input and output handshake in ONE
        do_reset();
        out_ready = 1'b0;
        drv(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        out_ready = 1'b1;
        drv(1'b1, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("sim_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("sim_main_sum", {24'd0, out_sum}, 32'hFE);
        chk("sim_out_valid", {31'd0, out_valid}, 32'd1);
        chk("sim_in_ready2", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b1;
        idle(3);

        // Counter wrap: 17 results with 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drv(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        idle(3);
        @(negedge clk);
        chk("wrap_count", {28'd0, result_count}, 32'd1);
        tick();

        // Reset with the skid full discards both results
        out_ready = 1'b0;
        drv(1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        drv(1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        @(negedge clk);
        chk("midrst_count", {28'd0, result_count}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
